rle_encoder: RTL and testbench
==============================

# rle_encoder

Zero run-length encoder that sits directly downstream of the `mat_scan` zig-zag stage. It consumes 64 zig-zag-ordered 10-bit signed coefficients per 8x8 block and emits JPEG-style tokens: DC, AC(run, level), ZRL (16 zeros) and EOB. A small internal token FIFO absorbs ZRL bursts, so input is accepted every cycle with no backpressure.

## Interface
- `FIFO_DEPTH`, 8: token FIFO entries; power of two, ≥ 4.
- `DW`, 10: coefficient width, two's complement.
- `clk`  in  1  sole clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `vld_in`  in  1  `din` valid this cycle; one coefficient accepted per asserted cycle.
- `din`  in  DW  coefficient, zig-zag order, index 0 = DC.
- `vld_out`  out  1  token valid, one-cycle strobe per token.
- `tok_type`  out  2  0 = DC, 1 = AC, 2 = ZRL, 3 = EOB.
- `run`  out  4  preceding zero count for AC; 15 for ZRL; 0 for DC and EOB.
- `level`  out  DW  coefficient value for DC/AC; 0 for ZRL and EOB.
- `ovf`  out  1  sticky FIFO-overflow error; cleared only by `rst`.

## Operation
- Block index `idx` (6 bits) advances only on `vld_in`. It wraps 63→0, so back-to-back blocks need no gap. Gaps in `vld_in` are allowed anywhere.
- Zero counter `zcnt` (6 bits) is cleared at `idx`==0.
- `idx`==0: enqueue DC with `level`=`din`, even if `din` is zero. Set `zcnt`=0.
- `idx` 1..63, `din`==0: `zcnt`++. Nothing is enqueued, except at `idx`==63.
- `idx` 1..63, `din`≠0: enqueue one entry {`zrl`=`zcnt`[5:4], AC, `run`=`zcnt`[3:0], `level`=`din`}. Set `zcnt`=0.
- `idx`==63, `din`==0: enqueue EOB with `zrl`=0. Trailing zeros are discarded and never emitted as ZRL.
- `idx`==63, `din`≠0: AC as above, then no EOB.
- FIFO entry = {`zrl`[1:0], `tok_type`, `run`, `level`}.
- Output serializer expands each popped entry:
  - First it emits `zrl` ZRL tokens, one per cycle.
  - Then it emits the entry's own token.
  - It pops the next entry in the cycle after the last token goes out.
- The serializer emits at most one token per cycle. `vld_out` is low whenever the FIFO is empty and no expansion is in progress.
- Write when full: the entry is dropped and `ovf` is set. This is unreachable for legal streams at depth 8; it exists for verification.
- Token count per block is ≤ 64.

## Timing
- Reset values: `vld_out`=0, `tok_type`=0, `run`=0, `level`=0, `ovf`=0. FIFO is empty, `idx`=0, `zcnt`=0, serializer idle.
- `rst` asserted mid-block aborts the block. No EOB is emitted and FIFO contents are discarded. The first `vld_in` after release is treated as DC.
- Latency, for an entry with `zrl`=0, idle serializer and empty FIFO:
  - The coefficient is accepted on edge k.
  - `vld_out` goes high after edge k+2.
  - Each leading ZRL adds one cycle.
- FIFO order is strict. Tokens are never reordered across entries or blocks.
- Simultaneous push and pop on a full FIFO is legal (no overflow). On an empty FIFO, push and pop in the same cycle is not a bypass: the pop sees the entry on the next cycle.

## Structure
- Package `rle_pkg` holds:
  - `tok_t` enum: `TOK_DC`, `TOK_AC`, `TOK_ZRL`, `TOK_EOB`.
  - Constants `BLK_N`=64 and `ZRL_RUN`=15.
  - Packed entry struct `rle_entry_t`.
- Sub-module `sync_fifo`, parameterized width and depth: single clock, synchronous active-high reset, with `full`/`empty` flags.
- Serializer states: `IDLE`, `ZRL`, `TOK`.
  - `IDLE`→`ZRL` on pop with `zrl`>0; `IDLE`→`TOK` on pop with `zrl`=0.
  - `ZRL`→`TOK` once the remaining-ZRL count reaches 0.
  - `TOK`→`IDLE`, or pop the next entry directly.

## Test plan
- Input 0..63 run through the `mat_scan` order (0, 1, 8, 16, 9, …, 63) -> DC(0) followed by 63 AC tokens with `run`=0 and `level` in that order; no EOB; 64 tokens total.
- DC=5, idx1=−3 (10'h3FD), rest 0 -> DC(5), AC(0, 10'h3FD), EOB; 3 tokens.
- idx 1..47 = 0, idx48=7, rest 0 -> DC, ZRL, ZRL, AC(15, 7), EOB. Check the ZRL cycles are contiguous on `vld_out`.
- All-zero block -> DC(0), EOB only. Two back-to-back blocks with no `vld_in` gap -> correct DC on the second block; `ovf`=0.
- Random `vld_in` gaps, 100 random blocks versus a reference model -> token-exact match; `ovf` never set.
- `rst` pulsed at idx=30 with tokens pending -> outputs 0 the next cycle; the following block encodes cleanly starting from DC.

Source files
------------

// File: rtl/rle_encoder_pkg.sv
// Shared types and constants for the zero run-length encoder: token codes,
// block geometry and the packed FIFO entry carried between encoder and serializer.
package rle_pkg;

   localparam int BLK_N   = 64;
   localparam int ZRL_RUN = 15;
   localparam int COEF_W  = 10;
   localparam int RUN_W   = 4;
   localparam int IDX_W   = $clog2(BLK_N);

   typedef enum logic [1:0] {
      TOK_DC  = 2'd0,
      TOK_AC  = 2'd1,
      TOK_ZRL = 2'd2,
      TOK_EOB = 2'd3
   } tok_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ZRL  = 2'd1,
      TOK  = 2'd2
   } ser_state_t;

   // zrl = number of 16-zero ZRL tokens to emit ahead of the entry's own token
   typedef struct packed {
      logic [1:0]        zrl;
      tok_t              tok;
      logic [RUN_W-1:0]  run;
      logic [COEF_W-1:0] level;
   } rle_entry_t;

   function automatic rle_entry_t mk_entry(input logic [1:0]        zrl,
                                           input tok_t              tok,
                                           input logic [RUN_W-1:0]  run,
                                           input logic [COEF_W-1:0] level);
      rle_entry_t e;
      e.zrl   = zrl;
      e.tok   = tok;
      e.run   = run;
      e.level = level;
      return e;
   endfunction

   function automatic ser_state_t entry_state(input rle_entry_t e);
      return (e.zrl != 2'd0) ? ZRL : TOK;
   endfunction

endpackage

// File: rtl/rle_encoder_if.sv
// Coefficient input stream and token output stream of the run-length encoder.
interface rle_encoder_if #(parameter int DW = rle_pkg::COEF_W);
   import rle_pkg::*;

   logic          vld_in;
   logic [DW-1:0] din;
   logic          vld_out;
   tok_t          tok_type;
   logic [3:0]    run;
   logic [DW-1:0] level;
   logic          ovf;

   modport master (
      output vld_in, din,
      input  vld_out, tok_type, run, level, ovf
   );

   modport slave (
      input  vld_in, din,
      output vld_out, tok_type, run, level, ovf
   );

endinterface

// File: rtl/rle_encoder_sync_fifo.sv
// Single-clock FIFO with occupancy counter; a push while full is dropped
// unless a pop happens in the same cycle.
module sync_fifo #(
   parameter  int WIDTH = 8,
   parameter  int DEPTH = 8,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      cnt;
   logic             wr_en;
   logic             rd_en;

   assign full  = (cnt == (AW+1)'(DEPTH));
   assign empty = (cnt == '0);
   assign wr_en = push && (!full || pop);
   assign rd_en = pop && !empty;
   assign rdata = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_ptr] <= wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (wr_en) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (rd_en) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         unique case ({wr_en, rd_en})
            2'b10:   cnt <= cnt + (AW+1)'(1);
            2'b01:   cnt <= cnt - (AW+1)'(1);
            default: cnt <= cnt;
         endcase
      end
   end

endmodule

// File: rtl/rle_encoder.sv
// Zero run-length encoder: turns 64 zig-zag coefficients per block into
// DC / AC(run, level) / ZRL / EOB tokens through a small entry FIFO.
//
// state | meaning
// IDLE  | nothing being expanded; pop an entry as soon as the FIFO has one
// ZRL   | emitting the popped entry's leading ZRL tokens, rem_q left
// TOK   | emitting the entry's own token; chain straight into the next entry
module rle_encoder
   import rle_pkg::*;
#(
   parameter int FIFO_DEPTH = 8,
   parameter int DW         = COEF_W
) (
   input  logic         clk,
   input  logic         rst,
   rle_encoder_if.slave bus
);

   localparam int EW = $bits(rle_entry_t);

   logic [IDX_W-1:0] idx_q;
   logic [IDX_W-1:0] idx_d;
   logic [IDX_W-1:0] zcnt_q;
   logic [IDX_W-1:0] zcnt_d;
   logic             push;
   rle_entry_t       push_entry;

   logic             pop;
   logic [EW-1:0]    rdata_raw;
   rle_entry_t       pop_entry;
   logic             full;
   logic             empty;

   ser_state_t       state_q;
   ser_state_t       state_d;
   logic [1:0]       rem_q;
   logic [1:0]       rem_d;
   rle_entry_t       cur_q;
   rle_entry_t       cur_d;

   logic             vld_out_q;
   logic             vld_out_d;
   tok_t             tok_q;
   tok_t             tok_d;
   logic [3:0]       run_q;
   logic [3:0]       run_d;
   logic [DW-1:0]    level_q;
   logic [DW-1:0]    level_d;
   logic             ovf_q;

   // Block scan: one entry per nonzero AC, a DC at idx 0 and an EOB only when
   // the block ends on a zero, so trailing zeros never become ZRL tokens.
   always_comb begin
      idx_d      = idx_q;
      zcnt_d     = zcnt_q;
      push       = 1'b0;
      push_entry = mk_entry(2'd0, TOK_DC, '0, '0);
      if (bus.vld_in) begin
         idx_d = idx_q + IDX_W'(1);
         if (idx_q == '0) begin
            push       = 1'b1;
            push_entry = mk_entry(2'd0, TOK_DC, '0, bus.din);
            zcnt_d     = '0;
         end else if (bus.din != '0) begin
            push       = 1'b1;
            push_entry = mk_entry(zcnt_q[IDX_W-1 -: 2], TOK_AC,
                                  zcnt_q[RUN_W-1:0], bus.din);
            zcnt_d     = '0;
         end else begin
            zcnt_d = zcnt_q + IDX_W'(1);
            if (idx_q == IDX_W'(BLK_N - 1)) begin
               push       = 1'b1;
               push_entry = mk_entry(2'd0, TOK_EOB, '0, '0);
            end
         end
      end
   end

   sync_fifo #(
      .WIDTH (EW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .wdata (push_entry),
      .rdata (rdata_raw),
      .full  (full),
      .empty (empty)
   );

   assign pop_entry = rle_entry_t'(rdata_raw);

   always_comb begin
      state_d   = state_q;
      rem_d     = rem_q;
      cur_d     = cur_q;
      pop       = 1'b0;
      vld_out_d = 1'b0;
      tok_d     = TOK_DC;
      run_d     = '0;
      level_d   = '0;
      unique case (state_q)
         IDLE: begin
            if (!empty) begin
               pop     = 1'b1;
               cur_d   = pop_entry;
               rem_d   = pop_entry.zrl;
               state_d = entry_state(pop_entry);
            end
         end
         ZRL: begin
            vld_out_d = 1'b1;
            tok_d     = TOK_ZRL;
            run_d     = 4'(ZRL_RUN);
            rem_d     = rem_q - 2'd1;
            if (rem_q == 2'd1) begin
               state_d = TOK;
            end
         end
         TOK: begin
            vld_out_d = 1'b1;
            tok_d     = cur_q.tok;
            run_d     = cur_q.run;
            level_d   = cur_q.level;
            // popping here keeps one token per cycle for runs of zrl=0 entries
            if (!empty) begin
               pop     = 1'b1;
               cur_d   = pop_entry;
               rem_d   = pop_entry.zrl;
               state_d = entry_state(pop_entry);
            end else begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         idx_q     <= '0;
         zcnt_q    <= '0;
         state_q   <= IDLE;
         rem_q     <= '0;
         cur_q     <= mk_entry(2'd0, TOK_DC, '0, '0);
         vld_out_q <= 1'b0;
         tok_q     <= TOK_DC;
         run_q     <= '0;
         level_q   <= '0;
         ovf_q     <= 1'b0;
      end else begin
         idx_q     <= idx_d;
         zcnt_q    <= zcnt_d;
         state_q   <= state_d;
         rem_q     <= rem_d;
         cur_q     <= cur_d;
         vld_out_q <= vld_out_d;
         tok_q     <= tok_d;
         run_q     <= run_d;
         level_q   <= level_d;
         if (push && full && !pop) begin
            ovf_q <= 1'b1;
         end
      end
   end

   assign bus.vld_out  = vld_out_q;
   assign bus.tok_type = tok_q;
   assign bus.run      = run_q;
   assign bus.level    = level_q;
   assign bus.ovf      = ovf_q;

endmodule

// File: tb/tb_rle_encoder.sv
// Self-checking bench for rle_encoder: table of sparse blocks, zig-zag ramp,
// back-to-back blocks, mid-block reset with latency check, and random blocks.
module tb_rle_encoder;

   typedef struct packed {
      logic [1:0] t;
      logic [3:0] run;
      logic [9:0] level;
   } tok_s;

   typedef struct {
      logic [9:0] dc;
      int         pos;
      logic [9:0] val;
      int         n_tok;
      int         n_zrl;
   } vec_t;

   logic clk;
   logic rst;
   rle_encoder_if #(.DW(10)) bus ();

   rle_encoder #(.FIFO_DEPTH(8), .DW(10)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int   checks;
   int   errors;
   int   tok_cnt;
   int   zrl_cnt;
   bit   prev_zrl;
   tok_s exp_q[$];
   logic [9:0] blk [64];
   int   zz [64];
   vec_t vecs [7];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #600000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   // Reference: tokens for the first n coefficients of blk, straight from the token rules.
   function automatic void model_push(input int n);
      int z;
      z = 0;
      for (int i = 0; i < n; i++) begin
         if (i == 0) begin
            exp_q.push_back('{t: 2'd0, run: 4'd0, level: blk[0]});
            z = 0;
         end else if (blk[i] == 10'd0) begin
            z++;
            if (i == 63) exp_q.push_back('{t: 2'd3, run: 4'd0, level: 10'd0});
         end else begin
            for (int k = 0; k < z / 16; k++)
               exp_q.push_back('{t: 2'd2, run: 4'd15, level: 10'd0});
            exp_q.push_back('{t: 2'd1, run: 4'(z % 16), level: blk[i]});
            z = 0;
         end
      end
   endfunction

   task automatic send_block(input int n, input bit gaps);
      for (int i = 0; i < n; i++) begin
         if (gaps && $urandom_range(3) == 0) begin
            repeat ($urandom_range(3, 1)) begin
               bus.vld_in = 1'b0;
               @(posedge clk); #1;
            end
         end
         bus.vld_in = 1'b1;
         bus.din    = blk[i];
         @(posedge clk); #1;
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      bus.vld_in = 1'b0;
      while (exp_q.size() != 0 && n < 400) begin
         @(posedge clk); #1;
         n++;
      end
      chk("drain_pending_tokens", 32'(exp_q.size()), 32'd0);
      repeat (4) @(posedge clk);
      #1;
   endtask

   // Token monitor on the falling edge.
   initial begin
      tok_s got;
      tok_s e;
      forever begin
         @(negedge clk);
         if (rst) begin
            prev_zrl = 1'b0;
         end else begin
            if (prev_zrl) begin
               checks++;
               if (!bus.vld_out) begin
                  errors++;
                  $display("FAIL zrl_contiguous: got vld_out=0 after ZRL, expected 1");
               end
            end
            prev_zrl = 1'b0;
            if (bus.vld_out) begin
               got = '{t: bus.tok_type, run: bus.run, level: bus.level};
               checks++;
               if (exp_q.size() == 0) begin
                  errors++;
                  $display("FAIL token_unexpected: got type=%0d run=%0d level=%03h, expected none",
                           got.t, got.run, got.level);
               end else begin
                  e = exp_q.pop_front();
                  if (got !== e) begin
                     errors++;
                     $display("FAIL token[%0d]: got type=%0d run=%0d level=%03h, expected type=%0d run=%0d level=%03h",
                              tok_cnt, got.t, got.run, got.level, e.t, e.run, e.level);
                  end
               end
               tok_cnt++;
               if (got.t == 2'd2) begin
                  zrl_cnt++;
                  prev_zrl = 1'b1;
               end
            end
         end
      end
   end

   initial begin
      int idx;
      int lo;
      int hi;
      int dens;
      logic [9:0] v;

      checks   = 0;
      errors   = 0;
      tok_cnt  = 0;
      zrl_cnt  = 0;
      prev_zrl = 1'b0;
      rst        = 1'b1;
      bus.vld_in = 1'b0;
      bus.din    = 10'd0;

      vecs[0] = '{dc: 10'd5,   pos: 1,  val: 10'h3FD, n_tok: 3, n_zrl: 0};
      vecs[1] = '{dc: 10'd0,   pos: 48, val: 10'd7,   n_tok: 5, n_zrl: 2};
      vecs[2] = '{dc: 10'd0,   pos: -1, val: 10'd0,   n_tok: 2, n_zrl: 0};
      vecs[3] = '{dc: 10'd1,   pos: 16, val: 10'd1,   n_tok: 3, n_zrl: 0};
      vecs[4] = '{dc: 10'd1,   pos: 17, val: 10'd2,   n_tok: 4, n_zrl: 1};
      vecs[5] = '{dc: 10'd0,   pos: 63, val: 10'd1,   n_tok: 5, n_zrl: 3};
      vecs[6] = '{dc: 10'h3FF, pos: 33, val: 10'd200, n_tok: 5, n_zrl: 2};

      idx = 0;
      for (int s = 0; s < 15; s++) begin
         lo = (s > 7) ? s - 7 : 0;
         hi = (s < 7) ? s : 7;
         if (s % 2 == 1) begin
            for (int r = lo; r <= hi; r++) begin zz[idx] = r * 8 + (s - r); idx++; end
         end else begin
            for (int r = hi; r >= lo; r--) begin zz[idx] = r * 8 + (s - r); idx++; end
         end
      end

      repeat (3) @(posedge clk);
      #1;
      chk("reset_vld_out", 32'(bus.vld_out), 32'd0);
      chk("reset_tok_type", 32'(bus.tok_type), 32'd0);
      chk("reset_run", 32'(bus.run), 32'd0);
      chk("reset_level", 32'(bus.level), 32'd0);
      chk("reset_ovf", 32'(bus.ovf), 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      // table-driven sparse blocks
      for (int t = 0; t < 7; t++) begin
         for (int i = 0; i < 64; i++) blk[i] = 10'd0;
         blk[0] = vecs[t].dc;
         if (vecs[t].pos > 0) blk[vecs[t].pos] = vecs[t].val;
         tok_cnt = 0;
         zrl_cnt = 0;
         model_push(64);
         send_block(64, 1'b0);
         drain();
         chk($sformatf("vec%0d_tokens", t), 32'(tok_cnt), 32'(vecs[t].n_tok));
         chk($sformatf("vec%0d_zrls", t), 32'(zrl_cnt), 32'(vecs[t].n_zrl));
      end

      // zig-zag ramp: DC(0) then 63 AC tokens back to back
      for (int i = 0; i < 64; i++) blk[i] = 10'(zz[i]);
      chk("zigzag_order_idx3", 32'(zz[3]), 32'd16);
      tok_cnt = 0;
      model_push(64);
      send_block(64, 1'b0);
      drain();
      chk("zigzag_tokens", 32'(tok_cnt), 32'd64);

      // two all-zero blocks without a gap, second DC nonzero
      for (int i = 0; i < 64; i++) blk[i] = 10'd0;
      tok_cnt = 0;
      model_push(64);
      send_block(64, 1'b0);
      blk[0] = 10'd9;
      model_push(64);
      send_block(64, 1'b0);
      drain();
      chk("b2b_tokens", 32'(tok_cnt), 32'd4);
      chk("b2b_ovf", 32'(bus.ovf), 32'd0);

      // reset at idx 30 with an entry still pending expansion
      for (int i = 0; i < 64; i++) blk[i] = 10'd0;
      blk[0]  = 10'd4;
      blk[28] = 10'd5;
      blk[29] = 10'd6;
      model_push(30);
      send_block(30, 1'b0);
      rst        = 1'b1;
      bus.vld_in = 1'b0;
      @(posedge clk); #1;
      chk("midrst_vld_out", 32'(bus.vld_out), 32'd0);
      chk("midrst_tok_type", 32'(bus.tok_type), 32'd0);
      chk("midrst_run", 32'(bus.run), 32'd0);
      chk("midrst_level", 32'(bus.level), 32'd0);
      exp_q.delete();
      prev_zrl = 1'b0;
      rst = 1'b0;
      @(posedge clk); #1;

      // clean block after reset, with the two-edge latency of the DC token
      for (int i = 0; i < 64; i++) blk[i] = 10'd0;
      blk[0] = 10'h012;
      blk[5] = 10'h033;
      tok_cnt = 0;
      model_push(64);
      for (int i = 0; i < 64; i++) begin
         bus.vld_in = 1'b1;
         bus.din    = blk[i];
         @(posedge clk); #1;
         if (i == 1) chk("latency_edge_k1", 32'(bus.vld_out), 32'd0);
         if (i == 2) begin
            chk("latency_edge_k2", 32'(bus.vld_out), 32'd1);
            chk("latency_dc_level", 32'(bus.level), 32'h012);
         end
      end
      drain();
      chk("post_rst_tokens", 32'(tok_cnt), 32'd3);

      // random blocks with random input gaps
      for (int b = 0; b < 100; b++) begin
         case ($urandom_range(2))
            0:       dens = 5;
            1:       dens = 35;
            default: dens = 80;
         endcase
         for (int i = 0; i < 64; i++) begin
            if (i == 0 || $urandom_range(99) < dens) begin
               v = 10'($urandom_range(1023));
               if (i != 0 && v == 10'd0) v = 10'd1;
               blk[i] = v;
            end else begin
               blk[i] = 10'd0;
            end
         end
         model_push(64);
         send_block(64, 1'b1);
      end
      drain();
      chk("random_ovf", 32'(bus.ovf), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
